core_mem_seq: RTL and testbench
===============================

// Module: core_mem_seq
// PURPOSE
//  Per-pipeline-step SRAM access sequencer; sits downstream of the core clock divider.
//  Detects each rising edge of the divided pipe_clk, sampled as a data signal in the clk domain.
//  On each edge it runs an instruction fetch, then an optional data load or store, on one single-port SRAM clocked by clk.
//  Fetched instruction and load data are held stable for the pipeline stages until the next step.
// PARAMETERS
//  AW      32  SRAM word-address width
//  DW      32  data width; must be a multiple of 8
//  RD_LAT  1   cycles from the sram_en cycle to valid sram_rdata; legal range 1..4
// PORTS
//  clk         in   1      system clock; pipe_clk is derived from it synchronously
//  rst_n       in   1      asynchronous active-low reset
//  pipe_clk    in   1      divided pipeline clock, sampled as a level
//  pc          in   AW     fetch address
//  mem_addr    in   AW     data address
//  mem_wdata   in   DW     store data
//  mem_be      in   DW/8   store byte enables
//  mem_re      in   1      load request for this step
//  mem_we      in   1      store request for this step
//  sram_en     out  1      SRAM access strobe, one-cycle pulse
//  sram_we     out  1      SRAM write, valid only with sram_en
//  sram_addr   out  AW     SRAM address
//  sram_wdata  out  DW     SRAM write data
//  sram_be     out  DW/8   SRAM byte enables
//  sram_rdata  in   DW     SRAM read data
//  instr       out  DW     last fetched instruction, held
//  load_data   out  DW     last load result, held
//  busy        out  1      high whenever state != IDLE
//  done        out  1      one-cycle pulse: sequence complete
//  overrun     out  1      sticky: a step arrived while busy
// BEHAVIOUR
//  - Reset, async: every output 0; pipe_q 0; state IDLE. Reset mid-sequence aborts with no further SRAM strobes.
//  - pipe_rise = pipe_clk & ~pipe_q; pipe_q <= pipe_clk every clk.
//  - pipe_rise in IDLE, cycle p: latch pc, mem_addr, mem_wdata, mem_be, mem_re, mem_we. Inputs are ignored otherwise.
//  - If mem_re and mem_we are both set, the store wins and no load is performed.
//  - FSM: IDLE -> IF_WAIT -> (MEM_WAIT | WR) -> DONE -> IDLE.
//  - Fetch: sram_en=1, sram_we=0, sram_be=all-ones, sram_addr=pc in cycle p+1. instr <= sram_rdata at end of cycle p+1+RD_LAT.
//  - Load: strobe with mem_addr in cycle p+RD_LAT+2. load_data <= sram_rdata at end of cycle p+2*RD_LAT+2.
//  - Store: sram_en=sram_we=1 with mem_addr, mem_wdata, mem_be in cycle p+RD_LAT+2. No wait follows; load_data is unchanged.
//  - done (state DONE), one cycle:
//      fetch-only at p+RD_LAT+2; store at p+RD_LAT+3; load at p+2*RD_LAT+3.
//  - done is high in the first cycle in which instr/load_data show new values.
//  - At most one sram_en per cycle. sram_addr, sram_wdata and sram_be hold their last value when sram_en=0.
//  - pipe_rise while busy: overrun <= 1 (cleared only by reset); that step is dropped and the current sequence completes normally.
//  - pipe_rise in the DONE cycle counts as busy.
//  - The 20-clk divider period exceeds the worst case, 2*RD_LAT+4 cycles, so overrun indicates a configuration fault.
//  - Address arithmetic: none; addresses pass through unmodified, with no wrap logic.
// TESTING
//  1. Reset mid-load (RD_LAT=1), rst_n low at cycle p+2 -> all outputs 0 at once; no sram_en after release until the next pipe_rise.
//  2. Fetch-only, RD_LAT=1, pc=0x10, rdata=0x00A00093 -> sram_en at p+1 addr 0x10; instr=0x00A00093 and done at p+3.
//  3. Load, RD_LAT=2, mem_addr=0x40, rdata=0xDEADBEEF -> fetch en at p+1, load en at p+4; load_data=0xDEADBEEF and done at p+7.
//  4. Store, mem_be=4'b0011, wdata=0x1234 -> en+we at p+3 with be 0011; done at p+4; load_data unchanged.
//  5. mem_re=mem_we=1 -> only a write strobe occurs; no read strobe; done at p+RD_LAT+3.
//  6. Second pipe_clk rise at p+2 during a sequence -> overrun=1 and stays 1; first sequence completes; no extra strobes.

Source files
------------

// File: rtl/core_mem_seq.sv
// core_mem_seq: per pipeline step, one instruction fetch then an optional
// load or store on a single-port SRAM, triggered by rising edges of pipe_clk.
module core_mem_seq #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_clk,
  input  logic [AW-1:0]   pc,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wdata,
  input  logic [DW/8-1:0] mem_be,
  input  logic            mem_re,
  input  logic            mem_we,
  output logic            sram_en,
  output logic            sram_we,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  output logic [DW/8-1:0] sram_be,
  input  logic [DW-1:0]   sram_rdata,
  output logic [DW-1:0]   instr,
  output logic [DW-1:0]   load_data,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  localparam int BW = DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    IF_WAIT,
    MEM_WAIT,
    WR,
    DONE
  } state_e;

  state_e          state_q;
  logic            pipe_q;
  logic [2:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic            re_q;
  logic            we_q;

  logic            en_q;
  logic            swe_q;
  logic [AW-1:0]   saddr_q;
  logic [DW-1:0]   swdata_q;
  logic [BW-1:0]   sbe_q;
  logic [DW-1:0]   instr_q;
  logic [DW-1:0]   ld_q;
  logic            done_q;
  logic            ovr_q;

  logic            pipe_rise;

  assign pipe_rise = pipe_clk & ~pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pipe_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      en_q     <= 1'b0;
      swe_q    <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
      sbe_q    <= '0;
      instr_q  <= '0;
      ld_q     <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      pipe_q <= pipe_clk;
      en_q   <= 1'b0;
      swe_q  <= 1'b0;
      done_q <= 1'b0;
      // A step landing on any non-idle state, DONE included, is dropped.
      if (pipe_rise && state_q != IDLE)
        ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (pipe_rise) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            be_q    <= mem_be;
            re_q    <= mem_re;
            we_q    <= mem_we;
            en_q    <= 1'b1;
            saddr_q <= pc;
            sbe_q   <= '1;
            cnt_q   <= 3'(RD_LAT);
            state_q <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (cnt_q == 3'd0) begin
            instr_q <= sram_rdata;
            if (we_q) begin
              en_q     <= 1'b1;
              swe_q    <= 1'b1;
              saddr_q  <= addr_q;
              swdata_q <= wdata_q;
              sbe_q    <= be_q;
              state_q  <= WR;
            end else if (re_q) begin
              en_q    <= 1'b1;
              saddr_q <= addr_q;
              sbe_q   <= '1;
              cnt_q   <= 3'(RD_LAT);
              state_q <= MEM_WAIT;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        MEM_WAIT: begin
          if (cnt_q == 3'd0) begin
            ld_q    <= sram_rdata;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        WR: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sram_en    = en_q;
  assign sram_we    = swe_q;
  assign sram_addr  = saddr_q;
  assign sram_wdata = swdata_q;
  assign sram_be    = sbe_q;
  assign instr      = instr_q;
  assign load_data  = ld_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_core_mem_seq.sv
// tb_core_mem_seq: two sequencers (RD_LAT 1 and 2) on shared stimulus,
// each with its own SRAM model, checked against a step-level model.
module tb_core_mem_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             pipe_clk;
  logic [31:0]      pc;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_re;
  logic             mem_we;
  logic [1:0]       sram_en;
  logic [1:0]       sram_we;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       overrun;
  logic [1:0][31:0] sram_addr;
  logic [1:0][31:0] sram_wdata;
  logic [1:0][31:0] sram_rdata;
  logic [1:0][31:0] instr;
  logic [1:0][31:0] load_data;
  logic [1:0][3:0]  sram_be;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f(input int i);
    if (i == 16) return 32'h00A00093;
    if (i == 64) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  logic [31:0] smem [2][256];
  logic [31:0] pl   [2][4];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    core_mem_seq #(
      .AW(32),
      .DW(32),
      .RD_LAT(g + 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pipe_clk  (pipe_clk),
      .pc        (pc),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .sram_en   (sram_en[g]),
      .sram_we   (sram_we[g]),
      .sram_addr (sram_addr[g]),
      .sram_wdata(sram_wdata[g]),
      .sram_be   (sram_be[g]),
      .sram_rdata(sram_rdata[g]),
      .instr     (instr[g]),
      .load_data (load_data[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .overrun   (overrun[g])
    );
    assign sram_rdata[g] = pl[g][g];
  end

  // SRAM: read data valid RD_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        for (int i = 0; i < 256; i++) smem[g][i] <= f(i);
      end else if (sram_en[g] && sram_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[g][b])
            smem[g][sram_addr[g][7:0]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
      end
      pl[g][0] <= (sram_en[g] && !sram_we[g]) ?
                  smem[g][sram_addr[g][7:0]] : $urandom;
      for (int k = 1; k < 4; k++) pl[g][k] <= pl[g][k-1];
    end
  end

  typedef struct {
    int          g;
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ev_t;

  typedef struct {
    int          g;
    int          cyc;
    logic [31:0] ins;
    logic [31:0] ld;
  } dn_t;

  ev_t evq[$];
  dn_t dnq[$];
  int  busy_n [2];
  int  stray_we = 0;

  always @(negedge clk) begin
    ev_t e;
    dn_t d;
    for (int g = 0; g < 2; g++) begin
      if (sram_en[g]) begin
        e.g = g; e.cyc = cyc; e.we = sram_we[g];
        e.addr = sram_addr[g]; e.wdata = sram_wdata[g]; e.be = sram_be[g];
        evq.push_back(e);
      end
      if (sram_we[g] && !sram_en[g]) stray_we++;
      if (done[g]) begin
        d.g = g; d.cyc = cyc; d.ins = instr[g]; d.ld = load_data[g];
        dnq.push_back(d);
      end
      if (busy[g]) busy_n[g]++;
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] refmem [256];
  logic [31:0] ref_ld;
  logic        ref_ovr;
  int          last_doff [2];

  task automatic chk(input string nm, input int g,
                     input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d(RD_LAT=%0d): got 0x%0h want 0x%0h",
               nm, g, g + 1, a, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_sram_en"}, g, 32'(sram_en[g]), 0);
      chk({tag, "_sram_we"}, g, 32'(sram_we[g]), 0);
      chk({tag, "_sram_addr"}, g, sram_addr[g], 0);
      chk({tag, "_sram_wdata"}, g, sram_wdata[g], 0);
      chk({tag, "_sram_be"}, g, 32'(sram_be[g]), 0);
      chk({tag, "_instr"}, g, instr[g], 0);
      chk({tag, "_load_data"}, g, load_data[g], 0);
      chk({tag, "_busy"}, g, 32'(busy[g]), 0);
      chk({tag, "_done"}, g, 32'(done[g]), 0);
      chk({tag, "_overrun"}, g, 32'(overrun[g]), 0);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) refmem[i] = f(i);
    ref_ld  = '0;
    ref_ovr = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        re;
    logic        we;
    int          r;
  } stim_t;

  function automatic stim_t mk(input logic [31:0] p_pc, input logic [31:0] p_a,
                               input logic [31:0] p_wd, input logic [3:0] p_be,
                               input logic p_re, input logic p_we, input int p_r);
    stim_t s;
    s.pc = p_pc; s.addr = p_a; s.wdata = p_wd; s.be = p_be;
    s.re = p_re; s.we = p_we; s.r = p_r;
    return s;
  endfunction

  // One 20-cycle pipeline step; s.r > 1 adds a second rise at p+s.r.
  task automatic run_step(input stim_t s);
    int          p;
    int          L;
    int          exp_done;
    int          n_exp;
    int          nd;
    int          b0 [2];
    logic [31:0] ins_new;
    logic [31:0] ld_new;
    ev_t         act[$];
    dn_t         dsel;
    @(negedge clk);
    pc = s.pc; mem_addr = s.addr; mem_wdata = s.wdata; mem_be = s.be;
    mem_re = s.re; mem_we = s.we; pipe_clk = 1'b1;
    p = cyc;
    b0[0] = busy_n[0];
    b0[1] = busy_n[1];
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        pc = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
        mem_be = 4'($urandom); mem_re = 1'($urandom); mem_we = 1'($urandom);
      end
      if (s.r > 1 && k == s.r - 1) pipe_clk = 1'b0;
      if (s.r > 1 && k == s.r) pipe_clk = 1'b1;
      if (k == 10) pipe_clk = 1'b0;
    end
    ins_new = refmem[s.pc[7:0]];
    ld_new  = (s.re && !s.we) ? refmem[s.addr[7:0]] : ref_ld;
    if (s.r > 1) ref_ovr = 1'b1;
    for (int g = 0; g < 2; g++) begin
      L = g + 1;
      exp_done = p + (s.we ? L + 3 : (s.re ? 2 * L + 3 : L + 2));
      act.delete();
      foreach (evq[i])
        if (evq[i].g == g && evq[i].cyc >= p && evq[i].cyc < p + 20)
          act.push_back(evq[i]);
      n_exp = (s.re || s.we) ? 2 : 1;
      chk("strobe_count", g, act.size(), n_exp);
      if (act.size() >= 1) begin
        chk("fetch_cyc", g, act[0].cyc - p, 1);
        chk("fetch_we", g, 32'(act[0].we), 0);
        chk("fetch_addr", g, act[0].addr, s.pc);
        chk("fetch_be", g, 32'(act[0].be), 32'hF);
      end
      if (act.size() >= 2) begin
        chk("mem_cyc", g, act[1].cyc - p, L + 2);
        chk("mem_we", g, 32'(act[1].we), 32'(s.we));
        chk("mem_addr", g, act[1].addr, s.addr);
        if (s.we) begin
          chk("mem_wdata", g, act[1].wdata, s.wdata);
          chk("mem_be", g, 32'(act[1].be), 32'(s.be));
        end
      end
      nd = 0;
      foreach (dnq[i])
        if (dnq[i].g == g && dnq[i].cyc >= p && dnq[i].cyc < p + 20) begin
          nd++;
          dsel = dnq[i];
        end
      chk("done_count", g, nd, 1);
      last_doff[g] = -1;
      if (nd == 1) begin
        last_doff[g] = dsel.cyc - p;
        chk("done_cyc", g, dsel.cyc - p, exp_done - p);
        chk("done_instr", g, dsel.ins, ins_new);
        chk("done_load", g, dsel.ld, ld_new);
      end
      chk("busy_cycles", g, busy_n[g] - b0[g], exp_done - p);
      chk("overrun", g, 32'(overrun[g]), 32'(ref_ovr));
      chk("instr_held", g, instr[g], ins_new);
      chk("load_held", g, load_data[g], ld_new);
    end
    ld_new = ld_new;
    ref_ld = ld_new;
    if (s.we)
      for (int b = 0; b < 4; b++)
        if (s.be[b]) refmem[s.addr[7:0]][8*b +: 8] = s.wdata[8*b +: 8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pipe_clk = 1'b0;
    pc = '0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    mem_re = 1'b0; mem_we = 1'b0;
    ref_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    stim_t       s;
    logic [31:0] ei;
    logic [31:0] el;
    int          d1;
    int          d2;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int p;
    int n;
    stim_t rs;
    tbl[0].s = mk(32'h10, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 0);
    tbl[0].ei = 32'h00A00093; tbl[0].el = 32'h0;        tbl[0].d1 = 3; tbl[0].d2 = 4;
    tbl[1].s = mk(32'h10, 32'h40, 32'h0, 4'hF, 1'b1, 1'b0, 0);
    tbl[1].ei = 32'h00A00093; tbl[1].el = 32'hDEADBEEF; tbl[1].d1 = 5; tbl[1].d2 = 7;
    tbl[2].s = mk(32'h10, 32'h80, 32'h1234, 4'b0011, 1'b0, 1'b1, 0);
    tbl[2].ei = 32'h00A00093; tbl[2].el = 32'hDEADBEEF; tbl[2].d1 = 4; tbl[2].d2 = 5;
    tbl[3].s = mk(32'h10, 32'h84, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 0);
    tbl[3].ei = 32'h00A00093; tbl[3].el = 32'hDEADBEEF; tbl[3].d1 = 4; tbl[3].d2 = 5;

    rst_n = 1'b0; pipe_clk = 1'b0;
    pc = '0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    mem_re = 1'b0; mem_we = 1'b0;
    ref_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      run_step(tbl[i].s);
      for (int g = 0; g < 2; g++) begin
        chk("tbl_done_off", g, last_doff[g], (g == 0) ? tbl[i].d1 : tbl[i].d2);
        chk("tbl_instr", g, instr[g], tbl[i].ei);
        chk("tbl_load", g, load_data[g], tbl[i].el);
      end
    end

    run_step(mk(32'h20, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 3));

    // Reset in the middle of a load sequence.
    @(negedge clk);
    pc = 32'h10; mem_addr = 32'h40; mem_re = 1'b1; mem_we = 1'b0;
    pipe_clk = 1'b1;
    p = cyc;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    ref_reset();
    @(negedge clk);
    pipe_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n = 0;
      foreach (evq[i])
        if (evq[i].g == g && evq[i].cyc >= p + 2 && evq[i].cyc < p + 20) n++;
      chk("rst_no_strobe", g, n, 0);
      n = 0;
      foreach (dnq[i])
        if (dnq[i].g == g && dnq[i].cyc >= p && dnq[i].cyc < p + 20) n++;
      chk("rst_no_done", g, n, 0);
      chk("rst_instr", g, instr[g], 0);
      chk("rst_load", g, load_data[g], 0);
      chk("rst_overrun", g, 32'(overrun[g]), 0);
    end

    run_step(mk(32'h30, 32'h40, 32'h0, 4'hF, 1'b1, 1'b0, 2));
    run_step(mk(32'h14, 32'h80, 32'h0, 4'hF, 1'b1, 1'b0, 0));

    do_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      rs = mk($urandom_range(0, 255), $urandom_range(120, 143), $urandom,
              4'($urandom), 1'($urandom), 1'($urandom), 0);
      run_step(rs);
    end

    chk("we_without_en", 0, stray_we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
